inst_seq_mem: RTL and testbench

Programmable instruction store and sequencer for the memory-interface read controller, replacing fixed per-benchmark instruction ROMs. The host writes a program (read-mask, shift, wfi and loop words) through a write port. After a START pulse the block fetches, decodes and issues read/shift words over a valid/ready handshake. It consumes wfi and loop words internally and repeats the program a programmable number of times.

---
 rtl/inst_seq_pkg.sv | 10 +
 rtl/inst_seq_mem_if.sv | 8 +
 rtl/inst_ram.sv | 18 +
 rtl/inst_seq_mem.sv | 102 ++++++++++
 tb/tb_inst_seq_mem.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/inst_seq_pkg.sv
// inst_seq_pkg: opcode, field and state definitions shared by the instruction sequencer.
package inst_seq_pkg;
  localparam int OP_LSB = 4;
  localparam int OP_MSB = 6;
  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_SHIFT = 3'b101;
  localparam logic [2:0] OP_WFI   = 3'b110;
  localparam logic [2:0] OP_LOOP  = 3'b111;
  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_DECODE, ST_HOLD, ST_WFI, ST_DONE} state_t;
endpackage

// File: rtl/inst_seq_mem_if.sv
// inst_seq_mem_if: valid/ready instruction issue channel to the read controller.
interface inst_seq_mem_if #(parameter int INST_WIDTH = 56);
  logic [INST_WIDTH-1:0] INST_DATA;
  logic INST_VALID;
  logic INST_READY;
  modport master (output INST_DATA, INST_VALID, input INST_READY);
  modport slave (input INST_DATA, INST_VALID, output INST_READY);
endinterface

// File: rtl/inst_ram.sv
// inst_ram: simple dual-port program store, synchronous write and registered read, no reset.
module inst_ram #(
  parameter int WIDTH = 56,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [1 << ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/inst_seq_mem.sv
// inst_seq_mem: programmable instruction store that fetches, decodes and issues read/shift words,
// absorbing wfi and loop words and repeating the program LOOP_COUNT extra times.
module inst_seq_mem import inst_seq_pkg::*; #(
  parameter int INST_WIDTH = 56,
  parameter int ADDR_WIDTH = 6,
  parameter int LOOP_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PROG_WE,
  input  logic [ADDR_WIDTH-1:0] PROG_ADDR,
  input  logic [INST_WIDTH-1:0] PROG_DATA,
  input  logic                  START,
  input  logic [LOOP_WIDTH-1:0] LOOP_COUNT,
  input  logic                  WAKE,
  inst_seq_mem_if.master        bus,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  WFI_ACTIVE,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [LOOP_WIDTH-1:0] ITER
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic [LOOP_WIDTH-1:0] iter, iter_n, loop_left, left_n;
  logic [INST_WIDTH-1:0] rdata, data, data_n;
  logic wake_pending, wake_n, idle, advance, do_loop;
  logic [2:0] op;
  assign idle = state == ST_IDLE || state == ST_DONE;
  assign op = rdata[OP_MSB:OP_LSB];
  inst_ram #(.WIDTH(INST_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(CLK), .we(PROG_WE & idle), .waddr(PROG_ADDR), .wdata(PROG_DATA),
    .raddr(pc), .rdata(rdata)
  );
  assign BUSY = !idle;
  assign DONE = state == ST_DONE;
  assign WFI_ACTIVE = state == ST_WFI;
  assign PC = pc;
  assign ITER = iter;
  assign bus.INST_DATA = data;
  assign bus.INST_VALID = state == ST_HOLD;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      pc <= '0;
      iter <= '0;
      loop_left <= '0;
      wake_pending <= 1'b0;
      data <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      iter <= iter_n;
      loop_left <= left_n;
      wake_pending <= wake_n;
      data <= data_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    iter_n = iter;
    left_n = loop_left;
    data_n = data;
    wake_n = wake_pending | (WAKE & !idle & state != ST_WFI);
    advance = 1'b0;
    do_loop = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (START) begin
        state_n = ST_READ;
        pc_n = '0;
        iter_n = '0;
        left_n = LOOP_COUNT;
        wake_n = 1'b0;
      end
      ST_READ: state_n = ST_DECODE;
      ST_DECODE: begin
        do_loop = op == OP_LOOP;
        state_n = op == OP_WFI ? ST_WFI : ST_HOLD;
        data_n = op == OP_WFI || op == OP_LOOP ? data : rdata;
      end
      ST_HOLD: advance = bus.INST_READY;
      ST_WFI: if (WAKE || wake_pending) begin
        advance = 1'b1;
        wake_n = 1'b0;
      end
      default: ;
    endcase
    // the last address behaves as an implicit LOOP word
    if (advance) begin
      do_loop = &pc;
      pc_n = pc + 1'b1;
      state_n = ST_READ;
    end
    if (do_loop) begin
      iter_n = iter + 1'b1;
      left_n = loop_left != 0 ? loop_left - 1'b1 : loop_left;
      pc_n = loop_left != 0 ? '0 : pc;
      state_n = loop_left != 0 ? ST_READ : ST_DONE;
    end
  end
endmodule

// File: tb/tb_inst_seq_mem.sv
// tb_inst_seq_mem: randomized directed runs of the sequencer checked against a program-level model.
module tb_inst_seq_mem;
  import inst_seq_pkg::*;
  localparam int IW = 56, AW = 6, LW = 8, DEPTH = 1 << AW, NONE = 1000;
  logic CLK = 0, RESET = 1, PROG_WE = 0, START = 0, WAKE = 0;
  logic [AW-1:0] PROG_ADDR = '0;
  logic [IW-1:0] PROG_DATA = '0;
  logic [LW-1:0] LOOP_COUNT = '0;
  logic BUSY, DONE, WFI_ACTIVE;
  logic [AW-1:0] PC;
  logic [LW-1:0] ITER;
  inst_seq_mem_if #(.INST_WIDTH(IW)) bus();
  inst_seq_mem #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .LOOP_WIDTH(LW)) dut (
    .CLK(CLK), .RESET(RESET), .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
    .START(START), .LOOP_COUNT(LOOP_COUNT), .WAKE(WAKE), .bus(bus), .BUSY(BUSY), .DONE(DONE),
    .WFI_ACTIVE(WFI_ACTIVE), .PC(PC), .ITER(ITER)
  );
  always #5 CLK = ~CLK;
  int n_pass = 0, n_chk = 0;
  int wfi_cnt, zero_ret, wake_cyc, exp_iter;
  int acc_cyc[$];
  logic [IW-1:0] prog [DEPTH];
  logic [IW-1:0] exp_q[$], got_q[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [IW-1:0] word(input logic [2:0] op);
    logic [63:0] r = {$urandom(), $urandom()};
    r[OP_MSB:OP_LSB] = op;
    return r[IW-1:0];
  endfunction
  task automatic load(input int a, input logic [IW-1:0] d);
    @(negedge CLK);
    PROG_WE = 1; PROG_ADDR = a[AW-1:0]; PROG_DATA = d; prog[a] = d;
    @(negedge CLK);
    PROG_WE = 0;
  endtask
  // expected issue order: each pass walks the program until a LOOP word or the end of memory
  task automatic model(input int lc);
    exp_q.delete();
    for (int it = 0; it <= lc; it++)
      for (int a = 0; a < DEPTH; a++) begin
        if (prog[a][OP_MSB:OP_LSB] == OP_LOOP) break;
        if (prog[a][OP_MSB:OP_LSB] != OP_WFI) exp_q.push_back(prog[a]);
      end
    exp_iter = lc + 1;
  endtask
  task automatic run(input int lc, input int ready_pct, input int wake_delay, input bit hold5, input bit we_during);
    logic stall = 0;
    logic [IW-1:0] pd = '0;
    logic [AW-1:0] ppc = '0, lpc = '0;
    int hold = 0, cyc = 0;
    bit held = 0;
    got_q.delete(); acc_cyc.delete();
    wfi_cnt = 0; zero_ret = 0; wake_cyc = -1;
    model(lc);
    @(negedge CLK);
    LOOP_COUNT = lc[LW-1:0]; START = 1;
    @(negedge CLK);
    START = 0;
    while (!DONE && cyc < 3000) begin
      if (stall) begin
        chk("hold_valid", bus.INST_VALID, 1);
        chk("hold_data", bus.INST_DATA, pd);
        chk("hold_pc", PC, ppc);
      end
      if (WFI_ACTIVE) wfi_cnt++;
      if (PC == 0 && lpc != 0) zero_ret++;
      lpc = PC;
      if (hold5 && !held && bus.INST_VALID) begin held = 1; hold = 5; end
      bus.INST_READY = hold > 0 ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (hold > 0) hold--;
      WAKE = (wake_delay < 0 && cyc == 0) || (wake_delay >= 0 && WFI_ACTIVE && wfi_cnt == wake_delay);
      if (WAKE && wake_delay >= 0) wake_cyc = cyc;
      PROG_WE = we_during && cyc == 5; PROG_ADDR = '1; PROG_DATA = ~prog[DEPTH-1];
      if (bus.INST_VALID && bus.INST_READY) begin got_q.push_back(bus.INST_DATA); acc_cyc.push_back(cyc); end
      stall = bus.INST_VALID && !bus.INST_READY; pd = bus.INST_DATA; ppc = PC;
      @(negedge CLK);
      cyc++;
    end
    WAKE = 0; PROG_WE = 0;
    chk("done", DONE, 1);
    chk("busy_after", BUSY, 0);
    chk("iter", ITER, exp_iter);
    chk("n_words", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("word", got_q[i], exp_q[i]);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, bus.INST_DATA, 0);
    chk({tag, "_valid"}, bus.INST_VALID, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_wfi"}, WFI_ACTIVE, 0);
    chk({tag, "_pc"}, PC, 0);
    chk({tag, "_iter"}, ITER, 0);
  endtask
  initial begin
    int n;
    bus.INST_READY = 1;
    foreach (prog[a]) prog[a] = '0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RESET = 0;
    // read/shift/loop, single pass, then three passes
    load(0, 56'h1); load(1, 56'h5F); load(2, 56'h70);
    run(0, 100, NONE, 0, 0);
    chk("first_issue_cyc", acc_cyc[0], 2);
    chk("second_issue_cyc", acc_cyc[1], 5);
    repeat (3) @(negedge CLK);
    chk("done_sticky", DONE, 1);
    run(2, 100, NONE, 0, 0);
    chk("pc_returns", zero_ret, 2);
    // random program with backpressure and a forced 5-cycle stall
    n = $urandom_range(3, 8);
    for (int a = 0; a < n; a++) load(a, word(3'($urandom_range(5))));
    load(n, word(OP_LOOP));
    run($urandom_range(1, 3), 60, NONE, 1, 0);
    // wfi with early and late wake
    load(0, word(OP_READ)); load(1, word(OP_WFI)); load(2, word(OP_SHIFT)); load(3, word(OP_LOOP));
    run(0, 100, -1, 0, 0);
    chk("wfi_early_cycles_le1", wfi_cnt <= 1, 1);
    chk("wfi_early_no_stall", acc_cyc[1], 8);
    run(0, 100, 10, 0, 0);
    chk("wfi_late_cycles", wfi_cnt, 10);
    chk("wake_to_valid", acc_cyc[1], wake_cyc + 3);
    // full memory of reads: wrap ends the run, mid-run writes are ignored
    for (int a = 0; a < DEPTH; a++) load(a, word(OP_READ));
    run(0, 100, NONE, 0, 1);
    // reset in HOLD, then rerun from PC 0
    load(0, word(OP_READ)); load(1, word(OP_SHIFT)); load(2, word(OP_LOOP));
    @(negedge CLK);
    START = 1; bus.INST_READY = 0;
    @(negedge CLK);
    START = 0;
    for (int i = 0; i < 10 && !bus.INST_VALID; i++) @(negedge CLK);
    chk("pre_reset_valid", bus.INST_VALID, 1);
    RESET = 1;
    @(negedge CLK);
    chk_zero("midrun_reset");
    RESET = 0; bus.INST_READY = 1;
    run(0, 100, NONE, 0, 0);
    chk("rerun_first_cyc", acc_cyc[0], 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
